keypad_emulator: RTL

Drives the 4x4 keypad column lines in response to the row scan, so that the keypad scanner decodes a key code supplied by on-chip logic (autoplay/demo mode, hardware self-test). It is the transmitting end of the keypad matrix interface: accepts a key code over a valid/ready handshake, presses that key for a fixed hold time, then releases it for a fixed gap. It sits between the game/demo controller and the keypad scanner's `keypadRow`/`keypadCol` pins, muxed with the physical keypad.

---
 rtl/keypad_emulator_if.sv | 21 ++
 rtl/keypad_emulator.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/keypad_emulator_if.sv
// Key request channel between the demo/self-test controller and the keypad emulator.
// Latency: none (wires only). Backpressure: key_ready gates key_valid transfers.
// The master drives key requests and cancel; the slave returns ready/busy/done status.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       cancel;
    logic       busy;
    logic       done;

    modport master (
        output key_code, key_valid, cancel,
        input  key_ready, busy, done
    );

    modport slave (
        input  key_code, key_valid, cancel,
        output key_ready, busy, done
    );
endinterface

// File: rtl/keypad_emulator.sv
// Presses a requested key on the 4x4 matrix (answers the row scan on the columns), holds it, then forces a release gap.
// Latency: PRESS from the cycle after transfer, keypadCol one cycle behind keypadRow. Backpressure: key_ready only in IDLE.
// Optional KEYPAD_EMU_BOUNCE_EN adds contact-bounce toggling at the start of PRESS and of GAP.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int GAP_CYCLES    = 5_000_000,
    parameter int BOUNCE_CYCLES = 500_000,
    parameter int BOUNCE_PERIOD = 50_000
) (
    input  logic                     clk,
    input  logic                     rst,
    keypad_emulator_if.slave         key_if,
    input  logic [3:0]               keypadRow,
    output logic [3:0]               keypadCol
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    // Reject parameter sets that would make a state shorter than its bounce window.
    if (HOLD_CYCLES < 2 || GAP_CYCLES < 2 || BOUNCE_PERIOD < 1 ||
        BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= GAP_CYCLES) begin : g_bad_params
        $error("keypad_emulator: invalid timing parameters");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       col_q, col_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pressed;

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [31:0] elapsed;
    logic        in_window;
    logic        phase_odd;

    always_comb begin
        elapsed   = 32'(cnt_q);
        in_window = elapsed < 32'(BOUNCE_CYCLES);
        phase_odd = ((elapsed / 32'(BOUNCE_PERIOD)) & 32'd1) != 32'd0;
        pressed   = 1'b0;
        case (state_q)
            ST_PRESS: pressed = in_window ? !phase_odd : 1'b1;
            ST_GAP:   pressed = in_window &&  phase_odd;
            default:  pressed = 1'b0;
        endcase
    end
`else
    always_comb begin
        pressed = (state_q == ST_PRESS);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Only the latched row is answered; other low row bits are ignored.
        if (pressed && !keypadRow[code_q[3:2]]) begin
            col_d = ~(4'b0001 << code_q[1:0]);
        end else begin
            col_d = 4'hF;
        end

        case (state_q)
            ST_IDLE: begin
                if (key_if.key_valid && ready_q) begin
                    state_d = ST_PRESS;
                    code_d  = key_if.key_code;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_PRESS: begin
                if (key_if.cancel || cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            col_q   <= 4'hF;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            col_q   <= col_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign keypadCol        = col_q;
    assign key_if.key_ready = ready_q;
    assign key_if.busy      = busy_q;
    assign key_if.done      = done_q;

endmodule
